mbinit_repair_partner_gen: RTL

//  Generic MBINIT repair-step responder for the module-partner side of the LTSM.
//  One instance serves REPAIRCLK (RESULT_W=3) or REPAIRVAL (RESULT_W=2) via parameterised sideband codes.

---
 rtl/mbinit_partner_pkg.sv | 42 ++++
 rtl/sb_timeout_counter.sv | 32 +++
 rtl/mbinit_repair_partner_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mbinit_partner_pkg.sv
// Shared definitions for MBINIT partner-side repair responders:
// state encoding and default REPAIRCLK / REPAIRVAL sideband message codes.
package mbinit_partner_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WAIT_INIT = 4'd1,
        ST_BUSY_INIT = 4'd2,
        ST_SEND_INIT = 4'd3,
        ST_WAIT_REQ  = 4'd4,
        ST_BUSY_RES  = 4'd5,
        ST_SEND_RES  = 4'd6,
        ST_BUSY_DONE = 4'd7,
        ST_SEND_DONE = 4'd8,
        ST_DONE      = 4'd9,
        ST_TIMEOUT   = 4'd10
    } state_e;

    localparam int RC_INIT_REQ    = 1;
    localparam int RC_INIT_RESP   = 2;
    localparam int RC_RESULT_REQ  = 3;
    localparam int RC_RESULT_RESP = 4;
    localparam int RC_DONE_REQ    = 5;
    localparam int RC_DONE_RESP   = 6;

    localparam int RV_INIT_REQ    = 7;
    localparam int RV_INIT_RESP   = 8;
    localparam int RV_RESULT_REQ  = 9;
    localparam int RV_RESULT_RESP = 10;
    localparam int RV_DONE_REQ    = 11;
    localparam int RV_DONE_RESP   = 12;

    function automatic logic is_send(input state_e s);
        return s inside {ST_SEND_INIT, ST_SEND_RES, ST_SEND_DONE};
    endfunction

    // States in which the partner may stall forever; BUSY_* rely on the arbiter.
    function automatic logic is_timed(input state_e s);
        return s inside {ST_WAIT_INIT, ST_WAIT_REQ, ST_SEND_INIT, ST_SEND_RES, ST_SEND_DONE};
    endfunction

endpackage

// File: rtl/sb_timeout_counter.sv
// Clearable up-counter that flags expiry after TIMEOUT_CYC running cycles.
module sb_timeout_counter #(
    parameter int TIMEOUT_CYC = 8000
) (
    input  logic CLK,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_r;

    // Count while running, park at the last value, clear on request.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_run && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_expired = i_run && (cnt_r == LAST);

endmodule

// File: rtl/mbinit_repair_partner_gen.sv
// MBINIT repair-step responder (partner side): answers init/result/done
// requests over sideband, latches the detection result, and times out.
module mbinit_repair_partner_gen
    import mbinit_partner_pkg::*;
#(
    parameter int RESULT_W    = 3,
    parameter int MSG_W       = 4,
    parameter int TIMEOUT_CYC = 8000,
    parameter int CNT_W       = 4,
    parameter logic [MSG_W-1:0] INIT_REQ    = MSG_W'(RC_INIT_REQ),
    parameter logic [MSG_W-1:0] INIT_RESP   = MSG_W'(RC_INIT_RESP),
    parameter logic [MSG_W-1:0] RESULT_REQ  = MSG_W'(RC_RESULT_REQ),
    parameter logic [MSG_W-1:0] RESULT_RESP = MSG_W'(RC_RESULT_RESP),
    parameter logic [MSG_W-1:0] DONE_REQ    = MSG_W'(RC_DONE_REQ),
    parameter logic [MSG_W-1:0] DONE_RESP   = MSG_W'(RC_DONE_RESP)
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                i_enable,
    input  logic [RESULT_W-1:0] i_result,
    input  logic [MSG_W-1:0]    i_RX_SbMessage,
    input  logic                i_msg_valid,
    input  logic                i_Busy_SideBand,
    input  logic                i_falling_edge_busy,
    output logic [MSG_W-1:0]    o_TX_SbMessage,
    output logic [RESULT_W-1:0] o_result,
    output logic                o_ValidOutData,
    output logic                o_end,
    output logic                o_timeout,
    output logic [CNT_W-1:0]    o_result_req_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e              cs_r;
    state_e              ns_s;
    logic                acc_init_s;
    logic                acc_res_s;
    logic                acc_done_s;
    logic                expired_s;
    logic                res_take_s;
    logic [RESULT_W-1:0] result_r;
    logic [CNT_W-1:0]    req_cnt_r;

    assign acc_init_s = i_msg_valid && (i_RX_SbMessage == INIT_REQ);
    assign acc_res_s  = i_msg_valid && (i_RX_SbMessage == RESULT_REQ);
    assign acc_done_s = i_msg_valid && (i_RX_SbMessage == DONE_REQ);
    assign res_take_s = (cs_r == ST_WAIT_REQ) && (ns_s == ST_BUSY_RES);

    sb_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .CLK       (CLK),
        .rst       (rst),
        .i_run     (is_timed(cs_r)),
        .i_clear   (ns_s != cs_r),
        .o_expired (expired_s)
    );

    // Next-state logic; a real exit condition beats an expiring timer.
    always_comb begin
        ns_s = cs_r;
        if (!i_enable) begin
            ns_s = ST_IDLE;
        end else begin
            case (cs_r)
                ST_IDLE:      ns_s = ST_WAIT_INIT;
                ST_WAIT_INIT: if (acc_init_s) ns_s = ST_BUSY_INIT;
                              else if (expired_s) ns_s = ST_TIMEOUT;
                              else ns_s = cs_r;
                ST_BUSY_INIT: if (!i_Busy_SideBand) ns_s = ST_SEND_INIT;
                              else ns_s = cs_r;
                ST_SEND_INIT: if (i_falling_edge_busy) ns_s = ST_WAIT_REQ;
                              else if (expired_s) ns_s = ST_TIMEOUT;
                              else ns_s = cs_r;
                ST_WAIT_REQ:  if (acc_res_s) ns_s = ST_BUSY_RES;
                              else if (acc_done_s) ns_s = ST_BUSY_DONE;
                              else if (expired_s) ns_s = ST_TIMEOUT;
                              else ns_s = cs_r;
                ST_BUSY_RES:  if (!i_Busy_SideBand) ns_s = ST_SEND_RES;
                              else ns_s = cs_r;
                ST_SEND_RES:  if (i_falling_edge_busy) ns_s = ST_WAIT_REQ;
                              else if (expired_s) ns_s = ST_TIMEOUT;
                              else ns_s = cs_r;
                ST_BUSY_DONE: if (!i_Busy_SideBand) ns_s = ST_SEND_DONE;
                              else ns_s = cs_r;
                ST_SEND_DONE: if (i_falling_edge_busy) ns_s = ST_DONE;
                              else if (expired_s) ns_s = ST_TIMEOUT;
                              else ns_s = cs_r;
                ST_DONE:      ns_s = ST_DONE;
                ST_TIMEOUT:   ns_s = ST_TIMEOUT;
                default:      ns_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cs_r <= ST_IDLE;
        end else begin
            cs_r <= ns_s;
        end
    end

    // Result is captured when the request is accepted, not when it is sent.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            result_r  <= {RESULT_W{1'b0}};
            req_cnt_r <= {CNT_W{1'b0}};
        end else begin
            result_r <= res_take_s ? i_result : result_r;
            if (ns_s == ST_IDLE) begin
                req_cnt_r <= {CNT_W{1'b0}};
            end else if (res_take_s && (req_cnt_r != CNT_MAX)) begin
                req_cnt_r <= req_cnt_r + CNT_W'(1);
            end else begin
                req_cnt_r <= req_cnt_r;
            end
        end
    end

    assign o_result_req_cnt = req_cnt_r;

    // Registered output decode from the next state.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            o_TX_SbMessage <= {MSG_W{1'b0}};
            o_result       <= {RESULT_W{1'b0}};
            o_ValidOutData <= 1'b0;
            o_end          <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            o_ValidOutData <= is_send(ns_s);
            o_end          <= (ns_s == ST_DONE);
            o_timeout      <= (ns_s == ST_TIMEOUT);
            o_result       <= (ns_s == ST_SEND_RES) ? result_r : {RESULT_W{1'b0}};
            case (ns_s)
                ST_SEND_INIT: o_TX_SbMessage <= INIT_RESP;
                ST_SEND_RES:  o_TX_SbMessage <= RESULT_RESP;
                ST_SEND_DONE: o_TX_SbMessage <= DONE_RESP;
                default:      o_TX_SbMessage <= {MSG_W{1'b0}};
            endcase
        end
    end

endmodule
